// File: rtl/arc4_pkg.sv
// arc4_pkg: shared types and constants for the ARC4 encryptor.
package arc4_pkg;

    localparam int KEY_BYTES = 3;
    localparam int S_SIZE    = 256;

    // Top-level sequencer states. The drop states are reachable only in the
    // ARC4_ENCRYPT_DROP256_EN build.
    typedef enum logic [3:0] {
        ST_IDLE,
        ST_INIT,
        ST_KSA_RD_I,
        ST_KSA_RD_J,
        ST_KSA_WR_I,
        ST_KSA_WR_J,
        ST_DROP,
        ST_DROP_STEP,
        ST_P_WAIT,
        ST_P_STEP,
        ST_P_OUT,
        ST_LEN
    } arc4_enc_state_t;

    // Key byte idx of a 24-bit key; byte 0 is the most significant.
    function automatic logic [7:0] keybyte(input logic [23:0] key, input logic [1:0] idx);
        return key[23-8*idx -: 8];
    endfunction

endpackage

// File: rtl/arc4_encrypt_if.sv
// arc4_encrypt_if: host handshake, plaintext stream, S memory and CT memory
// signals of the ARC4 encryptor. slave = encryptor side, master = environment.
interface arc4_encrypt_if;
    logic        en;
    logic        rdy;
    logic [23:0] key;
    logic        pt_valid;
    logic [7:0]  pt_data;
    logic        pt_last;
    logic        pt_ready;
    logic [7:0]  s_addr;
    logic [7:0]  s_rddata;
    logic [7:0]  s_wrdata;
    logic        s_wren;
    logic [7:0]  ct_addr;
    logic [7:0]  ct_wrdata;
    logic        ct_wren;
    logic        done;

    modport slave (
        input  en, key, pt_valid, pt_data, pt_last, s_rddata,
        output rdy, pt_ready, s_addr, s_wrdata, s_wren, ct_addr, ct_wrdata, ct_wren, done
    );

    modport master (
        output en, key, pt_valid, pt_data, pt_last, s_rddata,
        input  rdy, pt_ready, s_addr, s_wrdata, s_wren, ct_addr, ct_wrdata, ct_wren, done
    );
endinterface

// File: rtl/arc4_encrypt_prga_step.sv
// arc4_prga_step: one PRGA iteration on the external S memory.
// start_i is pulsed in the cycle the owner presents s_addr_o (= i+1 while idle);
// the step then runs RD_J, WR_I, WR_J, RD_K and the keystream byte appears on
// s_rddata in the cycle after last_o.
module arc4_prga_step (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       clr_i,
    input  logic       start_i,
    input  logic [7:0] s_rddata_i,
    output logic [7:0] s_addr_o,
    output logic [7:0] s_wrdata_o,
    output logic       s_wren_o,
    output logic       last_o
);
    localparam logic [2:0] SP_IDLE = 3'd0;
    localparam logic [2:0] SP_RD_J = 3'd1;
    localparam logic [2:0] SP_WR_I = 3'd2;
    localparam logic [2:0] SP_WR_J = 3'd3;
    localparam logic [2:0] SP_RD_K = 3'd4;

    logic [2:0] st_q, st_d;
    logic [7:0] i_q, i_d, j_q, j_d, si_q, si_d, sj_q, sj_d;

    // Swap/read sequencing and the S bus it drives in each step state.
    always_comb begin
        st_d       = st_q;
        i_d        = i_q;
        j_d        = j_q;
        si_d       = si_q;
        sj_d       = sj_q;
        s_addr_o   = i_q + 8'd1;
        s_wrdata_o = '0;
        s_wren_o   = 1'b0;
        case (st_q)
            SP_IDLE: if (start_i) begin
                i_d  = i_q + 8'd1;
                st_d = SP_RD_J;
            end
            SP_RD_J: begin
                si_d     = s_rddata_i;
                j_d      = j_q + s_rddata_i;
                s_addr_o = j_d;
                st_d     = SP_WR_I;
            end
            SP_WR_I: begin
                sj_d       = s_rddata_i;
                s_addr_o   = i_q;
                s_wrdata_o = s_rddata_i;
                s_wren_o   = 1'b1;
                st_d       = SP_WR_J;
            end
            SP_WR_J: begin
                s_addr_o   = j_q;
                s_wrdata_o = si_q;
                s_wren_o   = 1'b1;
                st_d       = SP_RD_K;
            end
            SP_RD_K: begin
                s_addr_o = si_q + sj_q;
                st_d     = SP_IDLE;
            end
            default: st_d = SP_IDLE;
        endcase
        if (clr_i) begin
            st_d = SP_IDLE;
            i_d  = '0;
            j_d  = '0;
        end
    end

    assign last_o = (st_q == SP_RD_K);

    // Step state and PRGA indices.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            st_q <= SP_IDLE;
            i_q  <= '0;
            j_q  <= '0;
            si_q <= '0;
            sj_q <= '0;
        end else begin
            st_q <= st_d;
            i_q  <= i_d;
            j_q  <= j_d;
            si_q <= si_d;
            sj_q <= sj_d;
        end
    end

endmodule

// File: rtl/arc4_encrypt.sv
// arc4_encrypt: streaming ARC4 encryptor. Runs S init + KSA on an external
// 256x8 memory, encrypts a valid/ready byte stream into CT[1..N], then writes
// N to CT[0] and pulses done.
// Build option: ARC4_ENCRYPT_DROP256_EN discards 256 keystream bytes after KSA.
module arc4_encrypt
    import arc4_pkg::*;
#(
    parameter int MAX_LEN = 255
) (
    input  logic          clk,
    input  logic          rst_n,
    arc4_encrypt_if.slave bus
);
    localparam logic [7:0] MAX_B  = 8'(MAX_LEN);
    localparam logic [7:0] S_LAST = 8'(S_SIZE - 1);
    localparam logic [1:0] K_LAST = 2'(KEY_BYTES - 1);

    arc4_enc_state_t state_q, state_d;
    logic [23:0] key_q, key_d;
    logic [7:0]  i_q, i_d, j_q, j_d, si_q, si_d, pt_q, pt_d, cnt_q, cnt_d;
    logic [1:0]  kidx_q, kidx_d;
    logic        last_q, last_d;
`ifdef ARC4_ENCRYPT_DROP256_EN
    logic [7:0]  drop_q, drop_d;
`endif

    logic [7:0] top_addr, top_wrdata, ct_addr, ct_wrdata;
    logic       top_wren, ct_wren, done;
    logic       step_clr, step_start, step_last, step_wren, use_step;
    logic [7:0] step_addr, step_wrdata;

    arc4_prga_step u_step (
        .clk        (clk),
        .rst_n      (rst_n),
        .clr_i      (step_clr),
        .start_i    (step_start),
        .s_rddata_i (bus.s_rddata),
        .s_addr_o   (step_addr),
        .s_wrdata_o (step_wrdata),
        .s_wren_o   (step_wren),
        .last_o     (step_last)
    );

    // Main sequencer: init, KSA, optional drop, per-byte PRGA and length write.
    always_comb begin
        state_d    = state_q;
        key_d      = key_q;
        i_d        = i_q;
        j_d        = j_q;
        si_d       = si_q;
        kidx_d     = kidx_q;
        pt_d       = pt_q;
        last_d     = last_q;
        cnt_d      = cnt_q;
`ifdef ARC4_ENCRYPT_DROP256_EN
        drop_d     = drop_q;
`endif
        top_addr   = '0;
        top_wrdata = '0;
        top_wren   = 1'b0;
        ct_addr    = '0;
        ct_wrdata  = '0;
        ct_wren    = 1'b0;
        done       = 1'b0;
        step_clr   = 1'b0;
        step_start = 1'b0;
        case (state_q)
            ST_IDLE: if (bus.en) begin
                key_d   = bus.key;
                i_d     = '0;
                cnt_d   = '0;
                state_d = ST_INIT;
            end
            ST_INIT: begin
                top_addr   = i_q;
                top_wrdata = i_q;
                top_wren   = 1'b1;
                step_clr   = 1'b1;
                i_d        = i_q + 8'd1;
                if (i_q == S_LAST) begin
                    j_d     = '0;
                    kidx_d  = '0;
                    state_d = ST_KSA_RD_I;
                end
            end
            ST_KSA_RD_I: begin
                top_addr = i_q;
                state_d  = ST_KSA_RD_J;
            end
            ST_KSA_RD_J: begin
                si_d     = bus.s_rddata;
                j_d      = j_q + bus.s_rddata + keybyte(key_q, kidx_q);
                top_addr = j_d;
                state_d  = ST_KSA_WR_I;
            end
            ST_KSA_WR_I: begin
                top_addr   = i_q;
                top_wrdata = bus.s_rddata;
                top_wren   = 1'b1;
                state_d    = ST_KSA_WR_J;
            end
            ST_KSA_WR_J: begin
                top_addr   = j_q;
                top_wrdata = si_q;
                top_wren   = 1'b1;
                kidx_d     = (kidx_q == K_LAST) ? 2'd0 : kidx_q + 2'd1;
                i_d        = i_q + 8'd1;
                if (i_q == S_LAST) begin
                    j_d = '0;
`ifdef ARC4_ENCRYPT_DROP256_EN
                    drop_d  = '0;
                    state_d = ST_DROP;
`else
                    state_d = ST_P_WAIT;
`endif
                end else begin
                    state_d = ST_KSA_RD_I;
                end
            end
`ifdef ARC4_ENCRYPT_DROP256_EN
            ST_DROP: begin
                step_start = 1'b1;
                state_d    = ST_DROP_STEP;
            end
            ST_DROP_STEP: if (step_last) begin
                drop_d  = drop_q + 8'd1;
                state_d = (drop_q == S_LAST) ? ST_P_WAIT : ST_DROP;
            end
`endif
            ST_P_WAIT: if (bus.pt_valid) begin
                step_start = 1'b1;
                pt_d       = bus.pt_data;
                last_d     = bus.pt_last;
                state_d    = ST_P_STEP;
            end
            ST_P_STEP: if (step_last) state_d = ST_P_OUT;
            ST_P_OUT: begin
                ct_addr   = cnt_q + 8'd1;
                ct_wrdata = pt_q ^ bus.s_rddata;
                ct_wren   = 1'b1;
                cnt_d     = cnt_q + 8'd1;
                state_d   = (last_q || (cnt_q + 8'd1 == MAX_B)) ? ST_LEN : ST_P_WAIT;
            end
            ST_LEN: begin
                ct_addr   = '0;
                ct_wrdata = cnt_q;
                ct_wren   = 1'b1;
                done      = 1'b1;
                state_d   = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // The PRGA step owns the S bus while waiting for a byte and while stepping.
    assign use_step = (state_q == ST_P_WAIT) || (state_q == ST_P_STEP) ||
                      (state_q == ST_DROP)   || (state_q == ST_DROP_STEP);

    assign bus.s_addr    = use_step ? step_addr   : top_addr;
    assign bus.s_wrdata  = use_step ? step_wrdata : top_wrdata;
    assign bus.s_wren    = use_step ? step_wren   : top_wren;
    assign bus.ct_addr   = ct_addr;
    assign bus.ct_wrdata = ct_wrdata;
    assign bus.ct_wren   = ct_wren;
    assign bus.done      = done;
    assign bus.rdy       = (state_q == ST_IDLE);
    assign bus.pt_ready  = (state_q == ST_P_WAIT);

    // Sequencer registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            key_q   <= '0;
            i_q     <= '0;
            j_q     <= '0;
            si_q    <= '0;
            kidx_q  <= '0;
            pt_q    <= '0;
            last_q  <= 1'b0;
            cnt_q   <= '0;
`ifdef ARC4_ENCRYPT_DROP256_EN
            drop_q  <= '0;
`endif
        end else begin
            state_q <= state_d;
            key_q   <= key_d;
            i_q     <= i_d;
            j_q     <= j_d;
            si_q    <= si_d;
            kidx_q  <= kidx_d;
            pt_q    <= pt_d;
            last_q  <= last_d;
            cnt_q   <= cnt_d;
`ifdef ARC4_ENCRYPT_DROP256_EN
            drop_q  <= drop_d;
`endif
        end
    end

endmodule

// File: tb/tb_arc4_encrypt.sv
// tb_arc4_encrypt: randomized self-checking bench for arc4_encrypt against a
// plain-arithmetic RC4 reference model.
module tb_arc4_encrypt;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    arc4_encrypt_if bus ();

    arc4_encrypt #(.MAX_LEN(255)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

`ifdef ARC4_ENCRYPT_DROP256_EN
    localparam int N_DROP = 256;
`else
    localparam int N_DROP = 0;
`endif

    logic [7:0] smem   [256];
    logic [7:0] ct_mem [256];
    logic [7:0] pt_buf [300];
    logic [7:0] ks_exp [300];
    logic       clr_ct = 1'b0;
    logic       done_prev = 1'b0;

    int vectors = 0, miscompares = 0;
    int ct_wr_total = 0, s_wr_total = 0, done_cnt = 0, done_long = 0;
    int run_ct_wr, run_done, stall_s_wr, stall_ct_wr;

    // S memory (1-cycle read), CT memory and write/done monitors.
    always @(posedge clk) begin
        if (bus.s_wren) begin
            smem[bus.s_addr] <= bus.s_wrdata;
            s_wr_total <= s_wr_total + 1;
        end
        bus.s_rddata <= smem[bus.s_addr];
        if (clr_ct) for (int a = 0; a < 256; a++) ct_mem[a] <= 8'h00;
        if (bus.ct_wren) begin
            ct_mem[bus.ct_addr] <= bus.ct_wrdata;
            ct_wr_total <= ct_wr_total + 1;
        end
        if (bus.done) done_cnt <= done_cnt + 1;
        if (bus.done && done_prev) done_long <= done_long + 1;
        done_prev <= bus.done;
    end

    // RC4 (optionally drop-256) keystream for key k, n bytes, into ks_exp.
    task automatic ref_keystream(input logic [23:0] k, input int n);
        int s [256];
        int kb [3];
        int i, j, t;
        kb[0] = int'(k[23:16]);
        kb[1] = int'(k[15:8]);
        kb[2] = int'(k[7:0]);
        for (int a = 0; a < 256; a++) s[a] = a;
        j = 0;
        for (int a = 0; a < 256; a++) begin
            j = (j + s[a] + kb[a % 3]) % 256;
            t = s[a]; s[a] = s[j]; s[j] = t;
        end
        i = 0; j = 0;
        for (int m = 0; m < N_DROP + n; m++) begin
            i = (i + 1) % 256;
            j = (j + s[i]) % 256;
            t = s[i]; s[i] = s[j]; s[j] = t;
            if (m >= N_DROP) ks_exp[m - N_DROP] = 8'(s[(s[i] + s[j]) % 256]);
        end
    endtask

    // Present one byte from a negedge until the DUT takes it.
    task automatic send_byte(input logic [7:0] d, input logic l, output bit ok);
        int n;
        n = 0;
        bus.pt_valid = 1'b1;
        bus.pt_data  = d;
        bus.pt_last  = l;
        while (!bus.pt_ready && n < 5000) begin
            @(negedge clk);
            n++;
        end
        ok = bus.pt_ready;
        @(negedge clk);
        bus.pt_valid = 1'b0;
        bus.pt_last  = 1'b0;
        bus.pt_data  = 8'($urandom);
    endtask

    // Start a run with key k and stream pt_buf[0..n-1]; optional stall after
    // byte stall_at and an en poke after byte poke_at (-1 disables).
    task automatic run_msg(input logic [23:0] k, input int n, input bit use_last,
                           input int stall_at, input int stall_len, input int poke_at);
        int ct0, d0, t, s0, c0;
        bit ok;
        clr_ct = 1'b1;
        @(negedge clk);
        clr_ct = 1'b0;
        ct0 = ct_wr_total;
        d0  = done_cnt;
        stall_s_wr  = 0;
        stall_ct_wr = 0;
        t = 0;
        while (!bus.rdy && t < 5000) begin @(negedge clk); t++; end
        bus.key = k;
        bus.en  = 1'b1;
        @(negedge clk);
        bus.en  = 1'b0;
        bus.key = 24'($urandom);
        for (int b = 0; b < n; b++) begin
            send_byte(pt_buf[b], use_last && (b == n - 1), ok);
            if (!ok) begin
                vectors++; miscompares++;
                $display("FAIL pt_ready_timeout byte=%0d got pt_ready=0 want 1", b);
                return;
            end
            if (b == poke_at) begin
                bus.en  = 1'b1;
                bus.key = ~k;
                @(negedge clk);
                bus.en  = 1'b0;
            end
            if (b == stall_at) begin
                repeat (8) @(negedge clk);
                s0 = s_wr_total;
                c0 = ct_wr_total;
                repeat (stall_len - 8) @(negedge clk);
                stall_s_wr  = s_wr_total - s0;
                stall_ct_wr = ct_wr_total - c0;
            end
        end
        t = 0;
        while (done_cnt == d0 && t < 100) begin @(negedge clk); t++; end
        if (done_cnt == d0) begin
            vectors++; miscompares++;
            $display("FAIL done_timeout got no done pulse want 1");
        end
        @(negedge clk);
        run_ct_wr = ct_wr_total - ct0;
        run_done  = done_cnt - d0;
    endtask

    task automatic load_plaintext();
        string p;
        p = "Plaintext";
        for (int b = 0; b < 9; b++) pt_buf[b] = p[b];
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        vectors++;
        if ({bus.rdy, bus.pt_ready, bus.s_wren, bus.ct_wren, bus.done} !== 5'b10000) begin
            miscompares++;
            $display("FAIL reset_flags got %b want 10000",
                     {bus.rdy, bus.pt_ready, bus.s_wren, bus.ct_wren, bus.done});
        end
        vectors++;
        if ({bus.s_addr, bus.s_wrdata, bus.ct_addr, bus.ct_wrdata} !== 32'h0) begin
            miscompares++;
            $display("FAIL reset_buses got %h want 0",
                     {bus.s_addr, bus.s_wrdata, bus.ct_addr, bus.ct_wrdata});
        end
        rst_n = 1'b1;
        @(negedge clk);
        vectors++;
        if (bus.rdy !== 1'b1) begin
            miscompares++;
            $display("FAIL reset_rdy got %b want 1", bus.rdy);
        end
    endtask

    task automatic test_plaintext();
        logic [7:0] vec [9];
        vec = '{8'hBB, 8'hF3, 8'h16, 8'hE8, 8'hD9, 8'h40, 8'hAF, 8'h0A, 8'hD3};
        load_plaintext();
        ref_keystream(24'h4B6579, 9);
        run_msg(24'h4B6579, 9, 1'b1, -1, 0, -1);
        for (int b = 0; b < 9; b++) begin
            vectors++;
            if (ct_mem[b+1] !== (pt_buf[b] ^ ks_exp[b])) begin
                miscompares++;
                $display("FAIL t1_ct[%0d] got %02h want %02h", b+1, ct_mem[b+1], pt_buf[b] ^ ks_exp[b]);
            end
`ifndef ARC4_ENCRYPT_DROP256_EN
            vectors++;
            if (ct_mem[b+1] !== vec[b]) begin
                miscompares++;
                $display("FAIL t1_vector[%0d] got %02h want %02h", b+1, ct_mem[b+1], vec[b]);
            end
`endif
        end
        vectors++;
        if (ct_mem[0] !== 8'h09) begin
            miscompares++; $display("FAIL t1_len got %02h want 09", ct_mem[0]);
        end
        vectors++;
        if (run_done != 1 || done_long != 0) begin
            miscompares++; $display("FAIL t1_done got pulses=%0d long=%0d want 1,0", run_done, done_long);
        end
        vectors++;
        if (run_ct_wr != 10) begin
            miscompares++; $display("FAIL t1_ct_writes got %0d want 10", run_ct_wr);
        end
        vectors++;
        if (bus.rdy !== 1'b1) begin
            miscompares++; $display("FAIL t1_rdy got %b want 1", bus.rdy);
        end
    endtask

    task automatic test_keystream();
        for (int b = 0; b < 3; b++) pt_buf[b] = 8'h00;
        ref_keystream(24'h4B6579, 3);
        run_msg(24'h4B6579, 3, 1'b1, -1, 0, -1);
        for (int b = 0; b < 3; b++) begin
            vectors++;
            if (ct_mem[b+1] !== ks_exp[b]) begin
                miscompares++;
                $display("FAIL t2_ks[%0d] got %02h want %02h", b+1, ct_mem[b+1], ks_exp[b]);
            end
        end
`ifndef ARC4_ENCRYPT_DROP256_EN
        vectors++;
        if ({ct_mem[1], ct_mem[2], ct_mem[3]} !== 24'hEB9F77) begin
            miscompares++;
            $display("FAIL t2_vector got %02h%02h%02h want EB9F77", ct_mem[1], ct_mem[2], ct_mem[3]);
        end
`endif
        vectors++;
        if (ct_mem[0] !== 8'h03 || run_done != 1) begin
            miscompares++; $display("FAIL t2_len got %02h done=%0d want 03,1", ct_mem[0], run_done);
        end
    endtask

    task automatic test_stall();
        load_plaintext();
        ref_keystream(24'h4B6579, 9);
        run_msg(24'h4B6579, 9, 1'b1, 1, 50, -1);
        for (int b = 0; b < 9; b++) begin
            vectors++;
            if (ct_mem[b+1] !== (pt_buf[b] ^ ks_exp[b])) begin
                miscompares++;
                $display("FAIL t3_ct[%0d] got %02h want %02h", b+1, ct_mem[b+1], pt_buf[b] ^ ks_exp[b]);
            end
        end
        vectors++;
        if (stall_s_wr != 0 || stall_ct_wr != 0) begin
            miscompares++;
            $display("FAIL t3_stall_writes got s=%0d ct=%0d want 0,0", stall_s_wr, stall_ct_wr);
        end
        vectors++;
        if (ct_mem[0] !== 8'h09 || run_ct_wr != 10) begin
            miscompares++; $display("FAIL t3_len got %02h writes=%0d want 09,10", ct_mem[0], run_ct_wr);
        end
    endtask

    task automatic test_max_len();
        logic [23:0] k;
        int ready_seen, c0;
        k = 24'($urandom);
        for (int b = 0; b < 300; b++) pt_buf[b] = 8'($urandom);
        ref_keystream(k, 255);
        run_msg(k, 255, 1'b0, -1, 0, -1);
        for (int b = 0; b < 255; b++) begin
            vectors++;
            if (ct_mem[b+1] !== (pt_buf[b] ^ ks_exp[b])) begin
                miscompares++;
                $display("FAIL t4_ct[%0d] got %02h want %02h", b+1, ct_mem[b+1], pt_buf[b] ^ ks_exp[b]);
            end
        end
        vectors++;
        if (ct_mem[0] !== 8'hFF || run_done != 1 || run_ct_wr != 256) begin
            miscompares++;
            $display("FAIL t4_len got %02h done=%0d writes=%0d want FF,1,256", ct_mem[0], run_done, run_ct_wr);
        end
        // Bytes 256.. offered with no pt_last: the block must not take them.
        ready_seen = 0;
        c0 = ct_wr_total;
        bus.pt_valid = 1'b1;
        for (int b = 255; b < 300; b++) begin
            bus.pt_data = pt_buf[b];
            repeat (6) begin
                @(negedge clk);
                if (bus.pt_ready) ready_seen++;
            end
        end
        bus.pt_valid = 1'b0;
        vectors++;
        if (ready_seen != 0 || ct_wr_total != c0) begin
            miscompares++;
            $display("FAIL t4_overflow got ready=%0d writes=%0d want 0,0", ready_seen, ct_wr_total - c0);
        end
    endtask

    task automatic test_reset_mid_ksa();
        bus.key = 24'h123456;
        bus.en  = 1'b1;
        @(negedge clk);
        bus.en  = 1'b0;
        repeat (400) @(negedge clk);
        rst_n = 1'b0;
        #1;
        vectors++;
        if ({bus.rdy, bus.pt_ready, bus.s_wren, bus.ct_wren, bus.done} !== 5'b10000 ||
            {bus.s_addr, bus.s_wrdata, bus.ct_addr, bus.ct_wrdata} !== 32'h0) begin
            miscompares++;
            $display("FAIL t5_async_reset got flags=%b buses=%h want 10000,0",
                     {bus.rdy, bus.pt_ready, bus.s_wren, bus.ct_wren, bus.done},
                     {bus.s_addr, bus.s_wrdata, bus.ct_addr, bus.ct_wrdata});
        end
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        vectors++;
        if (bus.rdy !== 1'b1) begin
            miscompares++; $display("FAIL t5_rdy got %b want 1", bus.rdy);
        end
        load_plaintext();
        ref_keystream(24'h4B6579, 9);
        run_msg(24'h4B6579, 9, 1'b1, -1, 0, -1);
        for (int b = 0; b < 9; b++) begin
            vectors++;
            if (ct_mem[b+1] !== (pt_buf[b] ^ ks_exp[b])) begin
                miscompares++;
                $display("FAIL t5_ct[%0d] got %02h want %02h", b+1, ct_mem[b+1], pt_buf[b] ^ ks_exp[b]);
            end
        end
        vectors++;
        if (ct_mem[0] !== 8'h09 || run_done != 1) begin
            miscompares++; $display("FAIL t5_len got %02h done=%0d want 09,1", ct_mem[0], run_done);
        end
    endtask

    task automatic test_en_ignored();
        load_plaintext();
        ref_keystream(24'h4B6579, 9);
        run_msg(24'h4B6579, 9, 1'b1, -1, 0, 3);
        for (int b = 0; b < 9; b++) begin
            vectors++;
            if (ct_mem[b+1] !== (pt_buf[b] ^ ks_exp[b])) begin
                miscompares++;
                $display("FAIL t6_ct[%0d] got %02h want %02h", b+1, ct_mem[b+1], pt_buf[b] ^ ks_exp[b]);
            end
        end
        vectors++;
        if (ct_mem[0] !== 8'h09 || run_done != 1 || run_ct_wr != 10) begin
            miscompares++;
            $display("FAIL t6_len got %02h done=%0d writes=%0d want 09,1,10", ct_mem[0], run_done, run_ct_wr);
        end
    endtask

    task automatic test_random();
        logic [23:0] k;
        int n, st;
        for (int r = 0; r < 3; r++) begin
            k  = 24'($urandom);
            n  = int'($urandom_range(1, 40));
            st = int'($urandom_range(0, 39));
            for (int b = 0; b < n; b++) pt_buf[b] = 8'($urandom);
            ref_keystream(k, n);
            run_msg(k, n, 1'b1, st, 20, -1);
            for (int b = 0; b < n; b++) begin
                vectors++;
                if (ct_mem[b+1] !== (pt_buf[b] ^ ks_exp[b])) begin
                    miscompares++;
                    $display("FAIL rnd%0d_ct[%0d] got %02h want %02h", r, b+1, ct_mem[b+1], pt_buf[b] ^ ks_exp[b]);
                end
            end
            vectors++;
            if (ct_mem[0] !== 8'(n) || run_ct_wr != n + 1) begin
                miscompares++;
                $display("FAIL rnd%0d_len got %02h writes=%0d want %02h,%0d", r, ct_mem[0], run_ct_wr, 8'(n), n + 1);
            end
        end
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog got no finish want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.en       = 1'b0;
        bus.key      = '0;
        bus.pt_valid = 1'b0;
        bus.pt_data  = '0;
        bus.pt_last  = 1'b0;
        test_reset();
        test_plaintext();
        test_keystream();
        test_stall();
        test_max_len();
        test_reset_mid_ksa();
        test_en_ignored();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/arc4_encrypt.md
Name: arc4_encrypt

Overview:
Streaming ARC4 encryptor. It is the producing end of the length-prefixed ciphertext memory that the key-search and decrypt blocks consume.
- Accepts a 24-bit key, runs init + KSA on an external 256x8 S memory, then encrypts a valid/ready plaintext byte stream.
- Writes ciphertext to CT memory at addresses 1..N, then writes the length N at address 0.
- Sits between a host/byte source and ct_mem; shares the S memory type used by arc4.

Parameters:
MAX_LEN, 255, maximum message length in bytes (1..255); byte MAX_LEN is forced to be last.

Ports:
clk  in  1  clock; all state on rising edge
rst_n  in  1  asynchronous active-low reset
en  in  1  start request; sampled only while rdy=1
rdy  out  1  1 = idle, ready for en
key  in  24  key, latched on accepted en; key[23:16] is key byte 0, key[7:0] is byte 2
pt_valid  in  1  plaintext byte valid
pt_data  in  8  plaintext byte
pt_last  in  1  marks final byte; qualified by pt_valid
pt_ready  out  1  block accepts a byte this cycle
s_addr  out  8  S memory address
s_rddata  in  8  S read data; 1-cycle synchronous read latency
s_wrdata  out  8  S write data
s_wren  out  1  S write enable
ct_addr  out  8  CT memory address
ct_wrdata  out  8  CT write data
ct_wren  out  1  CT write enable
done  out  1  one-cycle pulse when the length byte is written

Behaviour:
Reset and handshakes:
- Reset (async, any state): state=IDLE, rdy=1, pt_ready=0, s_wren=0, ct_wren=0, done=0, all addresses/data 0, i=j=count=0.
- en while rdy=1: latch key, rdy drops the next cycle. en while rdy=0 is ignored.
- Plaintext beat occurs when pt_valid && pt_ready. pt_ready=1 only in P_WAIT.

States:
- INIT: write s[n]=n for n=0..255, one per cycle (256 cycles), then KSA_RD_I with i=0, j=0.
- KSA_RD_I: s_addr=i.
- KSA_RD_J: si=s_rddata; j=j+si+keybyte[i mod 3] (mod 256); s_addr=new j.
- KSA_WR_I: write s[i]=s_rddata (sj).
- KSA_WR_J: write s[j]=si. If i==255, go to P_WAIT with i=j=0; else i++ and go to KSA_RD_I. KSA takes 4 cycles per iteration.
- P_WAIT: on beat, latch byte and last flag; i=i+1; s_addr=i+1.
- P_RD_J: si=s_rddata; j=j+si; s_addr=j.
- P_WR_I: write s[i]=sj.
- P_WR_J: write s[j]=si.
- P_RD_K: s_addr=si+sj.
- P_OUT: ct_addr=count+1, ct_wrdata=pt^s_rddata, ct_wren=1; count++.
  - If latched last or count+1==MAX_LEN, go to LEN; else P_WAIT.
- LEN: ct_addr=0, ct_wrdata=count, ct_wren=1, done=1, then IDLE (rdy=1).

Timing and arithmetic:
- Per-byte throughput: 6 cycles minimum (P_WAIT..P_OUT).
- All index arithmetic is 8-bit, wrapping mod 256.
- pt_last on the MAX_LEN-th byte is redundant and harmless. pt_last is ignored while pt_valid=0.
- Zero-length messages are not supported: the first accepted beat is always byte 1.
- Stalls: pt_valid low indefinitely holds P_WAIT with no memory writes.
- en pulses during a run have no effect; the run is not restarted.

Optional Feature:
Macro ARC4_ENCRYPT_DROP256_EN.
- Defined: after KSA, run 256 PRGA iterations with no plaintext and no CT writes (RC4-drop[256]) before the first P_WAIT. Adds 5x256 cycles.
- Undefined: plain ARC4, bit-compatible with the existing decrypt/crack path.

Decomposition:
- Package arc4_pkg holds:
  - state enum arc4_enc_state_t
  - KEY_BYTES=3 and S_SIZE=256 constants
  - function keybyte(key, idx) returning key[23-8*idx -: 8]
- One natural sub-module, arc4_prga_step: the 5-state swap/read sequencer shared by PRGA and the drop loop. The KSA stays inline.

Test Plan:
1. Key 0x4B6579 ("Key"), stream "Plaintext" with pt_last on 't' -> ct_mem[1..9]=BB F3 16 E8 D9 40 AF 0A D3, ct_mem[0]=0x09, one done pulse, rdy=1 afterwards.
2. Key 0x4B6579, 3 bytes 0x00 -> ct_mem[1..3]=EB 9F 77 (raw keystream), ct_mem[0]=0x03.
3. pt_valid held low 50 cycles between bytes 2 and 3 of test 1 -> identical CT contents; no ct_wren/s_wren during the stall.
4. 300 bytes with no pt_last, MAX_LEN=255 -> exactly 255 CT writes, ct_mem[0]=0xFF, done pulses, pt_ready=0 for bytes 256+.
5. Assert rst_n low mid-KSA, then restart test 1 -> outputs zero during reset, rdy=1 after release, test 1 results reproduced exactly.
6. en pulsed while rdy=0 mid-message -> ignored, key unchanged, results match test 1.
